// File: rtl/mem_axi_master_pkg.sv
// Shared types and constants for the mem<->AXI bridges.
package mem_axi_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  localparam logic       MEM_OP_RD         = 1'b0;
  localparam logic       MEM_OP_WR         = 1'b1;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // True when a burst starting at this page offset runs past the 4KB page.
  function automatic logic crosses_4k(input logic [11:0] offset,
                                      input int unsigned len_m1,
                                      input int unsigned beat_bytes);
    return (32'(offset) + (len_m1 + 32'd1) * beat_bytes) > 32'd4096;
  endfunction

endpackage

// File: rtl/mem_axi_master_if.sv
// AXI4 full-channel bundle for the gmem port, with master and slave views.
interface mem_axi_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned USER_W = 1
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              AWVALID, AWREADY, AWLOCK;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [ID_W-1:0]   AWID;
  logic [2:0]        AWSIZE, AWPROT;
  logic [1:0]        AWBURST;
  logic [3:0]        AWCACHE, AWQOS, AWREGION;
  logic [USER_W-1:0] AWUSER;

  logic              ARVALID, ARREADY, ARLOCK;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [ID_W-1:0]   ARID;
  logic [2:0]        ARSIZE, ARPROT;
  logic [1:0]        ARBURST;
  logic [3:0]        ARCACHE, ARQOS, ARREGION;
  logic [USER_W-1:0] ARUSER;

  logic              WVALID, WREADY, WLAST;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic [ID_W-1:0]   WID;
  logic [USER_W-1:0] WUSER;

  logic              BVALID, BREADY;
  logic [1:0]        BRESP;
  logic [ID_W-1:0]   BID;
  logic [USER_W-1:0] BUSER;

  logic              RVALID, RREADY, RLAST;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic [ID_W-1:0]   RID;
  logic [USER_W-1:0] RUSER;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
    input  AWREADY,
    output ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER,
    input  ARREADY,
    output WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
    input  WREADY,
    input  BVALID, BRESP, BID, BUSER,
    output BREADY,
    input  RVALID, RDATA, RLAST, RRESP, RID, RUSER,
    output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
    output AWREADY,
    input  ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER,
    output ARREADY,
    input  WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
    output WREADY,
    output BVALID, BRESP, BID, BUSER,
    input  BREADY,
    output RVALID, RDATA, RLAST, RRESP, RID, RUSER,
    input  RREADY
  );

endinterface

// File: rtl/mem_axi_master.sv
// Bridges simple mem read/write requests onto single-ID AXI4 INCR bursts, one burst in flight.
module mem_axi_master
  import mem_axi_master_pkg::*;
#(
  parameter int unsigned MEM_LEN_BITS      = 8,
  parameter int unsigned MEM_ADDR_BITS     = 32,
  parameter int unsigned MEM_DATA_BITS     = 64,
  parameter int unsigned MEM_AXI_DATA_BITS = 64,
  parameter int unsigned MEM_AXI_ADDR_BITS = 32,
  parameter int unsigned MEM_AXI_ID_BITS   = 1,
  parameter int unsigned MEM_AXI_USER_BITS = 1,
  parameter int unsigned MEM_AXI_STRB_BITS = MEM_AXI_DATA_BITS / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic                     mem_wr_valid,
  output logic                     mem_wr_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_valid,
  input  logic                     mem_rd_ready,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_err,
  mem_axi_master_if.master         m_axi_gmem
);

  localparam int unsigned SIZE_L = $clog2(MEM_AXI_STRB_BITS);

  if (MEM_DATA_BITS != MEM_AXI_DATA_BITS) begin : g_width_check
    $error("mem_axi_master: MEM_DATA_BITS must equal MEM_AXI_DATA_BITS");
  end

  state_t                   state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [MEM_LEN_BITS-1:0]  len_q, len_d;
  logic [MEM_LEN_BITS-1:0]  cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     last_beat;
  logic                     r_hs, w_hs;

  assign last_beat = (cnt_q == len_q);
  assign r_hs      = (state_q == S_RD_DATA) && m_axi_gmem.RVALID && mem_rd_ready;
  assign w_hs      = (state_q == S_WR_DATA) && mem_wr_valid && m_axi_gmem.WREADY;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Burst sequencing; RLAST/count disagreement flags an error but only RLAST ends a read.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_valid) begin
          addr_d  = mem_req_addr;
          len_d   = mem_req_len;
          cnt_d   = '0;
          state_d = (mem_req_opcode == MEM_OP_WR) ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (m_axi_gmem.ARREADY) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (r_hs) begin
          cnt_d = cnt_q + MEM_LEN_BITS'(1);
          if (m_axi_gmem.RRESP != AXI_RESP_OKAY) err_d = 1'b1;
          if (m_axi_gmem.RLAST != last_beat)     err_d = 1'b1;
          if (m_axi_gmem.RLAST)                  state_d = S_IDLE;
        end
      end
      S_WR_ADDR: if (m_axi_gmem.AWREADY) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + MEM_LEN_BITS'(1);
          if (last_beat) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_gmem.BVALID) begin
          if (m_axi_gmem.BRESP != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_ready = (state_q == S_IDLE);
  assign mem_err       = err_q;

  // Data channels are zero-latency pass-throughs gated by state.
  assign mem_rd_valid      = (state_q == S_RD_DATA) && m_axi_gmem.RVALID;
  assign mem_rd_bits       = MEM_DATA_BITS'(m_axi_gmem.RDATA);
  assign m_axi_gmem.RREADY = (state_q == S_RD_DATA) && mem_rd_ready;
  assign m_axi_gmem.WVALID = (state_q == S_WR_DATA) && mem_wr_valid;
  assign mem_wr_ready      = (state_q == S_WR_DATA) && m_axi_gmem.WREADY;
  assign m_axi_gmem.WDATA  = MEM_AXI_DATA_BITS'(mem_wr_bits);
  assign m_axi_gmem.WSTRB  = '1;
  assign m_axi_gmem.WLAST  = last_beat;
  assign m_axi_gmem.WID    = '0;
  assign m_axi_gmem.WUSER  = '0;
  assign m_axi_gmem.BREADY = (state_q == S_WR_RESP);

  assign m_axi_gmem.ARVALID  = (state_q == S_RD_ADDR);
  assign m_axi_gmem.ARADDR   = MEM_AXI_ADDR_BITS'(addr_q);
  assign m_axi_gmem.ARLEN    = 8'(len_q);
  assign m_axi_gmem.ARID     = '0;
  assign m_axi_gmem.ARSIZE   = 3'(SIZE_L);
  assign m_axi_gmem.ARBURST  = AXI_BURST_INCR;
  assign m_axi_gmem.ARLOCK   = 1'b0;
  assign m_axi_gmem.ARCACHE  = AXI_CACHE_DEFAULT;
  assign m_axi_gmem.ARPROT   = '0;
  assign m_axi_gmem.ARQOS    = '0;
  assign m_axi_gmem.ARREGION = '0;
  assign m_axi_gmem.ARUSER   = '0;

  assign m_axi_gmem.AWVALID  = (state_q == S_WR_ADDR);
  assign m_axi_gmem.AWADDR   = MEM_AXI_ADDR_BITS'(addr_q);
  assign m_axi_gmem.AWLEN    = 8'(len_q);
  assign m_axi_gmem.AWID     = '0;
  assign m_axi_gmem.AWSIZE   = 3'(SIZE_L);
  assign m_axi_gmem.AWBURST  = AXI_BURST_INCR;
  assign m_axi_gmem.AWLOCK   = 1'b0;
  assign m_axi_gmem.AWCACHE  = AXI_CACHE_DEFAULT;
  assign m_axi_gmem.AWPROT   = '0;
  assign m_axi_gmem.AWQOS    = '0;
  assign m_axi_gmem.AWREGION = '0;
  assign m_axi_gmem.AWUSER   = '0;

  logic unused_ok;
  assign unused_ok = ^{m_axi_gmem.RID, m_axi_gmem.BID, m_axi_gmem.RUSER, m_axi_gmem.BUSER};

  // Bursts are never split, so a request crossing a 4KB page is a client bug.
  a_no_4k_cross: assert property (@(posedge clock) disable iff (reset)
    (mem_req_valid && mem_req_ready) |->
      !crosses_4k(mem_req_addr[11:0], 32'(mem_req_len), MEM_AXI_STRB_BITS))
    else $error("mem_axi_master: request crosses a 4KB boundary");

endmodule

// File: tb/tb_mem_axi_master.sv
// Scoreboarded bench: host-side requests against a flat reference memory, random AXI slave timing.
module tb_mem_axi_master;
  import mem_axi_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic        mem_wr_valid, mem_wr_ready;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid, mem_rd_ready;
  logic [63:0] mem_rd_bits;
  logic        mem_err;

  mem_axi_master_if #(.ADDR_W(32), .DATA_W(64), .ID_W(1), .USER_W(1)) bus ();

  mem_axi_master #(
    .MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64), .MEM_AXI_DATA_BITS(64),
    .MEM_AXI_ADDR_BITS(32), .MEM_AXI_ID_BITS(1), .MEM_AXI_USER_BITS(1), .MEM_AXI_STRB_BITS(8)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_bits(mem_rd_bits),
    .mem_err(mem_err), .m_axi_gmem(bus)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } areq_t;

  int          n_cmp = 0, n_bad = 0;
  logic [63:0] ref_mem [int];
  logic [63:0] smem [int];
  areq_t       ar_exp[$], aw_exp[$];
  logic [63:0] rd_exp[$], w_exp[$], wr_data_q[$];
  int          ar_block = 0;
  bit          inj_bresp = 0, inj_early = 0;
  bit          busy_m = 0, err_m = 0, mon_en = 0;
  int          w_hs_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] init_word(input int idx);
    return {32'(idx) ^ 32'hA5A5_0000, ~32'(idx)};
  endfunction

  function automatic logic [63:0] ref_get(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] smem_get(input int idx);
    return smem.exists(idx) ? smem[idx] : init_word(idx);
  endfunction

  // Push expectations, then hold the request until accepted.
  task automatic issue(input bit op, input logic [31:0] addr, input int len,
                       input bit use_seed, input logic [63:0] seed);
    logic [63:0] d;
    int          endb;
    bit          acc;
    if (op) begin
      aw_exp.push_back('{addr, 8'(len)});
      for (int i = 0; i <= len; i++) begin
        d = (use_seed && i == 0) ? seed : {$urandom, $urandom};
        ref_mem[int'(addr >> 3) + i] = d;
        w_exp.push_back(d);
        wr_data_q.push_back(d);
      end
    end else begin
      ar_exp.push_back('{addr, 8'(len)});
      endb = inj_early ? 1 : len;
      for (int i = 0; i <= endb; i++) rd_exp.push_back(ref_get(int'(addr >> 3) + i));
    end
    mem_req_valid  = 1'b1;
    mem_req_opcode = op;
    mem_req_len    = 8'(len);
    mem_req_addr   = addr;
    for (int c = 0; ; c++) begin
      @(negedge clock);
      acc = mem_req_ready;
      @(posedge clock); #1;
      if (acc) break;
      if (c > 1000) begin fail("req_accept_timeout"); break; end
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((busy_m || ar_exp.size() != 0 || aw_exp.size() != 0 || rd_exp.size() != 0 ||
            w_exp.size() != 0) && c < 4000) begin
      @(posedge clock); #1;
      c++;
    end
    if (c >= 4000) fail({tag, "_idle_timeout"});
    @(posedge clock); #1;
  endtask

  // Monitor: every handshake pops and compares against the scoreboard.
  initial begin : monitor
    areq_t       a;
    bit          prev_arw = 0;
    logic [31:0] prev_araddr = '0;
    int          rd_cnt = 0, cur_len = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) continue;
      check("mem_err", 64'(mem_err), 64'(err_m));
      if (reset) begin
        busy_m = 0; err_m = 0; prev_arw = 0;
        continue;
      end
      check("req_ready", 64'(mem_req_ready), 64'(!busy_m));
      if (mem_req_valid && mem_req_ready) busy_m = 1;
      if (prev_arw) begin
        check("arvalid_hold", 64'(bus.ARVALID), 64'd1);
        check("araddr_hold", 64'(bus.ARADDR), 64'(prev_araddr));
      end
      prev_arw    = bus.ARVALID && !bus.ARREADY;
      prev_araddr = bus.ARADDR;
      if (bus.ARVALID && bus.ARREADY) begin
        if (ar_exp.size() == 0) fail("unexpected_ar");
        else begin
          a = ar_exp.pop_front();
          check("araddr", 64'(bus.ARADDR), 64'(a.addr));
          check("arlen", 64'(bus.ARLEN), 64'(a.len));
          check("ar_consts", 64'({bus.ARSIZE, bus.ARBURST, bus.ARCACHE}), 64'({3'd3, 2'b01, 4'b0011}));
          check("ar_zeros", 64'({bus.ARID, bus.ARLOCK, bus.ARPROT, bus.ARQOS, bus.ARREGION, bus.ARUSER}), 64'd0);
          cur_len = int'(a.len);
          rd_cnt  = 0;
        end
      end
      if (bus.AWVALID && bus.AWREADY) begin
        if (aw_exp.size() == 0) fail("unexpected_aw");
        else begin
          a = aw_exp.pop_front();
          check("awaddr", 64'(bus.AWADDR), 64'(a.addr));
          check("awlen", 64'(bus.AWLEN), 64'(a.len));
          check("aw_consts", 64'({bus.AWSIZE, bus.AWBURST, bus.AWCACHE}), 64'({3'd3, 2'b01, 4'b0011}));
          check("aw_zeros", 64'({bus.AWID, bus.AWLOCK, bus.AWPROT, bus.AWQOS, bus.AWREGION, bus.AWUSER,
                                 bus.WID, bus.WUSER}), 64'd0);
        end
      end
      if (bus.WVALID && bus.WREADY) begin
        w_hs_cnt++;
        check("wstrb", 64'(bus.WSTRB), 64'hFF);
        if (w_exp.size() == 0) fail("unexpected_w");
        else check("wdata", bus.WDATA, w_exp.pop_front());
      end
      if (mem_rd_valid && mem_rd_ready) begin
        if (rd_exp.size() == 0) fail("unexpected_rd");
        else check("rd_bits", mem_rd_bits, rd_exp.pop_front());
        if (bus.RLAST != (rd_cnt == cur_len)) err_m = 1;
        if (bus.RRESP != 2'b00) err_m = 1;
        rd_cnt++;
        if (bus.RLAST) busy_m = 0;
      end
      if (bus.BVALID && bus.BREADY) begin
        busy_m = 0;
        if (bus.BRESP != 2'b00) err_m = 1;
      end
    end
  end

  // AXI slave memory with random ready/valid timing.
  initial begin : axi_slave
    bit          s_rst, ar_hs, r_hs, aw_hs, w_hs, b_hs, c_rlast, c_wlast;
    logic [31:0] c_araddr, c_awaddr;
    int          c_arlen, c_awlen;
    logic [63:0] c_wdata;
    bit          rd_act = 0;
    int          rd_base = 0, rd_idx = 0, rd_end = 0;
    int          wr_ph = 0, wr_base = 0, wr_idx = 0, wr_len = 0, b_dly = 0;
    bus.AWREADY = 0; bus.ARREADY = 0; bus.WREADY = 0;
    bus.BVALID = 0; bus.BRESP = 0; bus.BID = 0; bus.BUSER = 0;
    bus.RVALID = 0; bus.RDATA = 0; bus.RLAST = 0; bus.RRESP = 0; bus.RID = 0; bus.RUSER = 0;
    forever begin
      @(negedge clock);
      s_rst    = reset;
      ar_hs    = bus.ARVALID && bus.ARREADY;  c_araddr = bus.ARADDR; c_arlen = int'(bus.ARLEN);
      aw_hs    = bus.AWVALID && bus.AWREADY;  c_awaddr = bus.AWADDR; c_awlen = int'(bus.AWLEN);
      r_hs     = bus.RVALID && bus.RREADY;    c_rlast  = bus.RLAST;
      w_hs     = bus.WVALID && bus.WREADY;    c_wdata  = bus.WDATA;  c_wlast = bus.WLAST;
      b_hs     = bus.BVALID && bus.BREADY;
      if (bus.ARVALID && !bus.ARREADY && ar_block > 0) ar_block--;
      @(posedge clock); #1;
      if (s_rst) begin
        rd_act = 0; wr_ph = 0;
        bus.ARREADY = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.RVALID = 0; bus.BVALID = 0;
        continue;
      end
      if (ar_hs) begin
        rd_act = 1; rd_base = int'(c_araddr >> 3); rd_idx = 0;
        rd_end = inj_early ? 1 : c_arlen;
      end
      if (r_hs) begin
        if (c_rlast) rd_act = 0;
        else rd_idx++;
      end
      if (!rd_act) bus.RVALID = 0;
      else if (!bus.RVALID || r_hs) begin
        bus.RVALID = ($urandom_range(0, 3) != 0);
        bus.RDATA  = smem_get(rd_base + rd_idx);
        bus.RLAST  = (rd_idx == rd_end);
        bus.RRESP  = 2'b00;
      end
      bus.ARREADY = !rd_act && (ar_block == 0) && ($urandom_range(0, 1) == 1);
      if (aw_hs) begin
        wr_ph = 1; wr_base = int'(c_awaddr >> 3); wr_idx = 0; wr_len = c_awlen;
      end
      if (w_hs) begin
        smem[wr_base + wr_idx] = c_wdata;
        check("wlast", 64'(c_wlast), 64'(wr_idx == wr_len));
        wr_idx++;
        if (c_wlast) begin wr_ph = 2; b_dly = $urandom_range(0, 3); end
      end
      if (b_hs) begin
        wr_ph = 0; bus.BVALID = 0;
      end else if (wr_ph == 2) begin
        if (b_dly > 0) b_dly--;
        else begin bus.BVALID = 1; bus.BRESP = inj_bresp ? 2'b10 : 2'b00; end
      end
      bus.AWREADY = (wr_ph == 0) && ($urandom_range(0, 1) == 1);
      bus.WREADY  = (wr_ph == 1) && ($urandom_range(0, 2) != 0);
    end
  end

  // Host write-data source and randomly toggling read-ready.
  initial begin : host_data
    bit hs;
    mem_wr_valid = 0; mem_wr_bits = '0; mem_rd_ready = 0;
    forever begin
      @(negedge clock);
      hs = mem_wr_valid && mem_wr_ready && !reset;
      @(posedge clock); #1;
      if (hs && wr_data_q.size() > 0) void'(wr_data_q.pop_front());
      mem_wr_valid = (wr_data_q.size() > 0) && ($urandom_range(0, 3) != 0);
      mem_wr_bits  = (wr_data_q.size() > 0) ? wr_data_q[0] : '0;
      mem_rd_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin : main
    int          len, off, base;
    logic [31:0] addr;
    mem_req_valid = 0; mem_req_opcode = 0; mem_req_len = '0; mem_req_addr = '0;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(mem_req_ready), 64'd1);
    check("rst_valids", 64'({bus.ARVALID, bus.AWVALID, bus.WVALID, mem_rd_valid}), 64'd0);
    check("rst_readies", 64'({bus.BREADY, bus.RREADY, mem_wr_ready}), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    check("rst_addr_len", 64'({bus.ARADDR, bus.AWLEN}), 64'd0);
    reset = 0;
    mon_en = 1;

    issue(MEM_OP_RD, 32'h1000, 3, 0, '0);          wait_idle("rd_len3");
    issue(MEM_OP_WR, 32'h40, 0, 1, 64'hDEADBEEF);  wait_idle("wr_len0");
    issue(MEM_OP_RD, 32'h40, 0, 0, '0);            wait_idle("rd_back");

    ar_block = 5;
    issue(MEM_OP_RD, 32'h2000, 7, 0, '0);          wait_idle("rd_backpressure");

    inj_bresp = 1;
    issue(MEM_OP_WR, 32'h80, 1, 0, '0);            wait_idle("wr_bresp_err");
    inj_bresp = 0;
    check("err_after_bresp", 64'(mem_err), 64'd1);
    inj_early = 1;
    issue(MEM_OP_RD, 32'h100, 3, 0, '0);           wait_idle("rd_early_last");
    inj_early = 0;
    check("err_sticky", 64'(mem_err), 64'd1);
    check("idle_after_err", 64'(mem_req_ready), 64'd1);

    // Back-to-back requests keep mem_req_valid high between acceptances.
    issue(MEM_OP_RD, 32'h1000, 3, 0, '0);
    issue(MEM_OP_WR, 32'h1800, 2, 0, '0);
    issue(MEM_OP_RD, 32'h1800, 2, 0, '0);
    for (int t = 0; t < 24; t++) begin
      len  = $urandom_range(0, 15);
      off  = $urandom_range(0, (4096 - (len + 1) * 8) / 8) * 8;
      base = $urandom_range(0, 3) * 4096;
      addr = 32'(base + off);
      issue(bit'($urandom_range(0, 1)), addr, len, 0, '0);
    end
    wait_idle("random");

    // Reset in the middle of an 8-beat write.
    base = w_hs_cnt;
    issue(MEM_OP_WR, 32'h8000, 7, 0, '0);
    for (int c = 0; c < 2000 && w_hs_cnt < base + 2; c++) begin
      @(posedge clock); #1;
    end
    if (w_hs_cnt < base + 2) fail("mid_write_timeout");
    reset = 1;
    @(posedge clock); #1;
    check("midrst_valids", 64'({bus.ARVALID, bus.AWVALID, bus.WVALID, mem_rd_valid, bus.BREADY}), 64'd0);
    check("midrst_req_ready", 64'(mem_req_ready), 64'd1);
    check("midrst_err", 64'(mem_err), 64'd0);
    reset = 0;
    wr_data_q.delete();
    w_exp.delete();
    repeat (2) @(posedge clock);
    #1;

    issue(MEM_OP_RD, 32'h1000, 3, 0, '0);          wait_idle("rd_after_reset");
    check("final_err", 64'(mem_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
